// File: rtl/object_raster_scanner.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | object_raster_scanner: VGA raster counters, sync and 8-object hit test.  |
// | Optional macro SCREEN_SNAPSHOT_EN latches object coordinates per frame.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module object_raster_scanner #(
    parameter int PIX_DIV      = 2,
    parameter int H_ACTIVE     = 640,
    parameter int H_TOTAL      = 800,
    parameter int H_SYNC_START = 656,
    parameter int H_SYNC_END   = 752,
    parameter int V_ACTIVE     = 480,
    parameter int V_TOTAL      = 525,
    parameter int V_SYNC_START = 490,
    parameter int V_SYNC_END   = 492,
    parameter int OBJ_W        = 32,
    parameter int OBJ_H        = 32
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] obj_x_1,
    input  logic [31:0] obj_x_2,
    input  logic [31:0] obj_x_3,
    input  logic [31:0] obj_x_4,
    input  logic [31:0] obj_x_5,
    input  logic [31:0] obj_x_6,
    input  logic [31:0] obj_x_7,
    input  logic [31:0] obj_x_8,
    input  logic [31:0] obj_y_1,
    input  logic [31:0] obj_y_2,
    input  logic [31:0] obj_y_3,
    input  logic [31:0] obj_y_4,
    input  logic [31:0] obj_y_5,
    input  logic [31:0] obj_y_6,
    input  logic [31:0] obj_y_7,
    input  logic [31:0] obj_y_8,
    output logic        pixel_tick,
    output logic [9:0]  pix_x,
    output logic [9:0]  pix_y,
    output logic        active_video,
    output logic        hsync,
    output logic        vsync,
    output logic [7:0]  hit_mask,
    output logic        hit_any,
    output logic [2:0]  hit_index,
    output logic [31:0] screen_end
);

    localparam int DIV_W = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
    localparam logic [DIV_W-1:0] c_div_last = DIV_W'(PIX_DIV - 1);
    localparam logic [9:0]  c_h_last     = 10'(H_TOTAL - 1);
    localparam logic [9:0]  c_v_last     = 10'(V_TOTAL - 1);
    localparam logic [9:0]  c_h_active   = 10'(H_ACTIVE);
    localparam logic [9:0]  c_v_active   = 10'(V_ACTIVE);
    localparam logic [9:0]  c_h_sync_beg = 10'(H_SYNC_START);
    localparam logic [9:0]  c_h_sync_end = 10'(H_SYNC_END);
    localparam logic [9:0]  c_v_sync_beg = 10'(V_SYNC_START);
    localparam logic [9:0]  c_v_sync_end = 10'(V_SYNC_END);
    localparam logic [10:0] c_obj_w      = 11'(OBJ_W);
    localparam logic [10:0] c_obj_h      = 11'(OBJ_H);

    logic [DIV_W-1:0] div_q;
    logic [9:0]       h_q, v_q, h_d, v_d;
    logic             tick_q, active_q, hsync_q, vsync_q, any_q, blank_q;
    logic [7:0]       mask_q;
    logic [2:0]       idx_q;

    logic             w_tick, w_h_wrap, w_v_wrap, w_frame_wrap, w_in_active;
    logic [10:0]      w_h11, w_v11;
    logic [7:0]       w_hit;
    logic [2:0]       w_idx;
    logic [31:0]      w_in_x [8];
    logic [31:0]      w_in_y [8];
    logic [31:0]      w_eff_x [8];
    logic [31:0]      w_eff_y [8];

    assign w_in_x = '{obj_x_1, obj_x_2, obj_x_3, obj_x_4, obj_x_5, obj_x_6, obj_x_7, obj_x_8};
    assign w_in_y = '{obj_y_1, obj_y_2, obj_y_3, obj_y_4, obj_y_5, obj_y_6, obj_y_7, obj_y_8};

    assign w_tick       = (div_q == c_div_last);
    assign w_h_wrap     = (h_q == c_h_last);
    assign w_v_wrap     = (v_q == c_v_last);
    assign w_frame_wrap = w_h_wrap & w_v_wrap;
    assign h_d          = w_h_wrap ? 10'd0 : h_q + 10'd1;
    assign v_d          = w_h_wrap ? (w_v_wrap ? 10'd0 : v_q + 10'd1) : v_q;
    assign w_h11        = {1'b0, h_d};
    assign w_v11        = {1'b0, v_d};
    assign w_in_active  = (h_d < c_h_active) & (v_d < c_v_active);

`ifdef SCREEN_SNAPSHOT_EN
    logic [31:0] snap_x_q [8];
    logic [31:0] snap_y_q [8];

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) begin
                snap_x_q[i] <= '1;
                snap_y_q[i] <= '1;
            end
        end else if (w_tick && w_frame_wrap) begin
            snap_x_q <= w_in_x;
            snap_y_q <= w_in_y;
        end
    end

    // Pixel (0,0) is tested on the capture edge itself, so it must see the
    // values being captured or the new frame would start with a stale pixel.
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            w_eff_x[i] = (w_tick && w_frame_wrap) ? w_in_x[i] : snap_x_q[i];
            w_eff_y[i] = (w_tick && w_frame_wrap) ? w_in_y[i] : snap_y_q[i];
        end
    end
`else
    assign w_eff_x = w_in_x;
    assign w_eff_y = w_in_y;
`endif

    for (genvar gi = 0; gi < 8; gi++) begin : g_obj
        logic [10:0] w_ox, w_oy;
        logic        w_shown, w_unused_hi;
        assign w_ox        = {1'b0, w_eff_x[gi][9:0]};
        assign w_oy        = {1'b0, w_eff_y[gi][9:0]};
        assign w_shown     = ~w_eff_x[gi][31] & ~w_eff_y[gi][31];
        assign w_unused_hi = ^{w_eff_x[gi][30:10], w_eff_y[gi][30:10]};
        assign w_hit[gi]   = w_shown & w_in_active
                           & (w_h11 >= w_ox) & (w_h11 < w_ox + c_obj_w)
                           & (w_v11 >= w_oy) & (w_v11 < w_oy + c_obj_h);
    end

    always_comb begin
        w_idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (w_hit[i]) w_idx = 3'(i);
        end
    end

    // All outputs describe the post-advance counter value, updated together.
    always_ff @(posedge clock) begin
        if (reset) begin
            div_q    <= '0;
            h_q      <= '0;
            v_q      <= '0;
            tick_q   <= 1'b0;
            active_q <= 1'b0;
            hsync_q  <= 1'b1;
            vsync_q  <= 1'b1;
            mask_q   <= '0;
            any_q    <= 1'b0;
            idx_q    <= '0;
            blank_q  <= 1'b0;
        end else begin
            tick_q <= w_tick;
            div_q  <= w_tick ? '0 : div_q + 1'b1;
            if (w_tick) begin
                h_q      <= h_d;
                v_q      <= v_d;
                active_q <= w_in_active;
                hsync_q  <= ~((h_d >= c_h_sync_beg) & (h_d < c_h_sync_end));
                vsync_q  <= ~((v_d >= c_v_sync_beg) & (v_d < c_v_sync_end));
                mask_q   <= w_hit;
                any_q    <= |w_hit;
                idx_q    <= w_idx;
                blank_q  <= (v_d >= c_v_active);
            end
        end
    end

    assign pixel_tick   = tick_q;
    assign pix_x        = h_q;
    assign pix_y        = v_q;
    assign active_video = active_q;
    assign hsync        = hsync_q;
    assign vsync        = vsync_q;
    assign hit_mask     = mask_q;
    assign hit_any      = any_q;
    assign hit_index    = idx_q;
    assign screen_end   = {31'd0, blank_q};

endmodule
`default_nettype wire

// File: tb/tb_object_raster_scanner.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_object_raster_scanner: directed bench on a reduced 40x30 raster.      |
// | Honours SCREEN_SNAPSHOT_EN for the frame-snapshot expectations.          |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_object_raster_scanner;

    localparam int PD  = 2;
    localparam int HA  = 32;
    localparam int HT  = 40;
    localparam int HSS = 34;
    localparam int HSE = 38;
    localparam int VA  = 24;
    localparam int VT  = 30;
    localparam int VSS = 26;
    localparam int VSE = 28;
    localparam int OW  = 8;
    localparam int OH  = 4;

    logic        clock, reset;
    logic [31:0] ox [8];
    logic [31:0] oy [8];
    logic        pixel_tick, active_video, hsync, vsync, hit_any;
    logic [9:0]  pix_x, pix_y;
    logic [7:0]  hit_mask;
    logic [2:0]  hit_index;
    logic [31:0] screen_end;

    int checks = 0;
    int errors = 0;

    int st_hits, st_minx, st_maxx, st_miny, st_maxy;
    int st_hs, st_vs, st_se, st_av, st_b1_left, st_b3_top;
    logic [7:0] st_last_mask;
    logic [2:0] st_last_idx;

    object_raster_scanner #(
        .PIX_DIV(PD), .H_ACTIVE(HA), .H_TOTAL(HT), .H_SYNC_START(HSS), .H_SYNC_END(HSE),
        .V_ACTIVE(VA), .V_TOTAL(VT), .V_SYNC_START(VSS), .V_SYNC_END(VSE),
        .OBJ_W(OW), .OBJ_H(OH)
    ) dut (
        .clock(clock), .reset(reset),
        .obj_x_1(ox[0]), .obj_x_2(ox[1]), .obj_x_3(ox[2]), .obj_x_4(ox[3]),
        .obj_x_5(ox[4]), .obj_x_6(ox[5]), .obj_x_7(ox[6]), .obj_x_8(ox[7]),
        .obj_y_1(oy[0]), .obj_y_2(oy[1]), .obj_y_3(oy[2]), .obj_y_4(oy[3]),
        .obj_y_5(oy[4]), .obj_y_6(oy[5]), .obj_y_7(oy[6]), .obj_y_8(oy[7]),
        .pixel_tick(pixel_tick), .pix_x(pix_x), .pix_y(pix_y),
        .active_video(active_video), .hsync(hsync), .vsync(vsync),
        .hit_mask(hit_mask), .hit_any(hit_any), .hit_index(hit_index),
        .screen_end(screen_end)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Rectangle coverage of each visible object at pixel (x,y), no coordinate wrap.
    function automatic logic [7:0] exp_mask(int x, int y);
        logic [7:0] m;
        int bx, by;
        m = 8'h00;
        for (int i = 0; i < 8; i++) begin
            bx = int'(ox[i][9:0]);
            by = int'(oy[i][9:0]);
            if (ox[i][31] == 1'b0 && oy[i][31] == 1'b0 && x < HA && y < VA &&
                x >= bx && x < bx + OW && y >= by && y < by + OH)
                m[i] = 1'b1;
        end
        return m;
    endfunction

    function automatic logic [2:0] low_index(logic [7:0] m);
        logic [2:0] r;
        r = 3'd0;
        for (int i = 7; i >= 0; i--) if (m[i]) r = 3'(i);
        return r;
    endfunction

    task automatic hide_all();
        for (int i = 0; i < 8; i++) begin
            ox[i] = 32'hFFFF_FFFF;
            oy[i] = 32'hFFFF_FFFF;
        end
    endtask

    task automatic wait_tick(output bit ok, output int nclk);
        ok = 1'b0;
        nclk = 0;
        for (int k = 0; k < 4 * PD + 4; k++) begin
            @(negedge clock);
            nclk++;
            if (pixel_tick === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic goto_frame_start(input string name, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 2 * PD * HT * VT + 16; k++) begin
            @(negedge clock);
            if (pixel_tick === 1'b1 && pix_x === 10'd0 && pix_y === 10'd0) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s frame_start: no tick at (0,0) within bound, got pix_x=%0d pix_y=%0d", name, pix_x, pix_y);
        end
    endtask

    task automatic scan_frame(input string name);
        bit ok;
        int nc, ex, ey, clk_total, seq_err, mask_err, sync_err, bx, by;
        logic [7:0] em;
        logic [2:0] eidx;
        logic e_hs, e_vs, e_av;
        st_hits = 0; st_minx = 9999; st_maxx = -1; st_miny = 9999; st_maxy = -1;
        st_hs = 0; st_vs = 0; st_se = 0; st_av = 0; st_b1_left = 0; st_b3_top = 0;
        st_last_mask = 8'h00; st_last_idx = 3'd0;
        ex = 0; ey = 0; clk_total = 0; seq_err = 0; mask_err = 0; sync_err = 0; bx = -1; by = -1;
        goto_frame_start(name, ok);
        if (!ok) return;
        for (int n = 0; n < HT * VT; n++) begin
            if (n > 0) begin
                wait_tick(ok, nc);
                clk_total += nc;
                if (!ok) begin
                    checks++; errors++;
                    $display("FAIL %s tick_timeout: no pixel_tick after pixel %0d", name, n);
                    return;
                end
            end
            if (pix_x !== 10'(ex) || pix_y !== 10'(ey)) seq_err++;
            em   = exp_mask(ex, ey);
            eidx = low_index(em);
            if (hit_mask !== em || hit_any !== (em != 8'h00) || hit_index !== eidx) begin
                if (mask_err == 0) begin bx = ex; by = ey; end
                mask_err++;
            end
            e_hs = !(ex >= HSS && ex < HSE);
            e_vs = !(ey >= VSS && ey < VSE);
            e_av = (ex < HA && ey < VA);
            if (hsync !== e_hs || vsync !== e_vs || active_video !== e_av ||
                screen_end !== ((ey >= VA) ? 32'h1 : 32'h0)) sync_err++;
            if (hit_mask !== 8'h00) begin
                st_hits++;
                st_last_mask = hit_mask;
                st_last_idx  = hit_index;
                if (ex < st_minx) st_minx = ex;
                if (ex > st_maxx) st_maxx = ex;
                if (ey < st_miny) st_miny = ey;
                if (ey > st_maxy) st_maxy = ey;
            end
            if (hit_mask[1] === 1'b1 && ex < 8) st_b1_left++;
            if (hit_mask[3] === 1'b1 && ey < 2) st_b3_top++;
            if (hsync === 1'b0) st_hs++;
            if (vsync === 1'b0) st_vs++;
            if (screen_end === 32'h1) st_se++;
            if (active_video === 1'b1) st_av++;
            ex++;
            if (ex == HT) begin ex = 0; ey++; end
        end
        wait_tick(ok, nc);
        clk_total += nc;
        checks++;
        if (!ok || pix_x !== 10'd0 || pix_y !== 10'd0 || seq_err != 0) begin
            errors++;
            $display("FAIL %s sequence: %0d out-of-order pixels, wrap to (%0d,%0d), required 0 and (0,0)", name, seq_err, pix_x, pix_y);
        end
        checks++;
        if (mask_err != 0) begin
            errors++;
            $display("FAIL %s hit_test: %0d wrong pixels, first at (%0d,%0d), required 0", name, mask_err, bx, by);
        end
        checks++;
        if (sync_err != 0) begin
            errors++;
            $display("FAIL %s sync_blank: %0d pixels with wrong hsync/vsync/active/screen_end, required 0", name, sync_err);
        end
        checks++;
        if (clk_total != PD * HT * VT) begin
            errors++;
            $display("FAIL %s frame_length: %0d clocks, required %0d", name, clk_total, PD * HT * VT);
        end
    endtask

    task automatic test_reset(input string name);
        int k;
        int nc;
        bit ok;
        @(negedge clock);
        reset = 1'b1;
        repeat (3) @(negedge clock);
        checks++;
        if (pixel_tick !== 1'b0 || pix_x !== 10'd0 || pix_y !== 10'd0 || active_video !== 1'b0) begin
            errors++;
            $display("FAIL %s raster_reset: tick=%b x=%0d y=%0d av=%b, required 0 0 0 0", name, pixel_tick, pix_x, pix_y, active_video);
        end
        checks++;
        if (hsync !== 1'b1 || vsync !== 1'b1) begin
            errors++;
            $display("FAIL %s sync_reset: hsync=%b vsync=%b, required 1 1", name, hsync, vsync);
        end
        checks++;
        if (hit_mask !== 8'h00 || hit_any !== 1'b0 || hit_index !== 3'd0) begin
            errors++;
            $display("FAIL %s hit_reset: mask=%h any=%b idx=%0d, required 00 0 0", name, hit_mask, hit_any, hit_index);
        end
        checks++;
        if (screen_end !== 32'h0) begin
            errors++;
            $display("FAIL %s screen_end_reset: got %h, required 00000000", name, screen_end);
        end
        reset = 1'b0;
        for (k = 1; k <= 8; k++) begin
            @(negedge clock);
            if (pixel_tick === 1'b1) break;
        end
        checks++;
        if (k != PD) begin
            errors++;
            $display("FAIL %s first_tick: after %0d clocks, required %0d", name, k, PD);
        end
        checks++;
        if (pix_x !== 10'd1 || pix_y !== 10'd0) begin
            errors++;
            $display("FAIL %s first_pixel: (%0d,%0d), required (1,0)", name, pix_x, pix_y);
        end
        wait_tick(ok, nc);
        checks++;
        if (!ok || nc != PD || pix_x !== 10'd2) begin
            errors++;
            $display("FAIL %s tick_period: %0d clocks to pix_x=%0d, required %0d to 2", name, nc, pix_x, PD);
        end
    endtask

    task automatic test_single();
        hide_all();
        ox[0] = 32'd4; oy[0] = 32'd8;
        scan_frame("single");
        checks++;
        if (st_hits != 32 || st_minx != 4 || st_maxx != 11 || st_miny != 8 || st_maxy != 11 ||
            st_last_mask !== 8'h01 || st_last_idx !== 3'd0) begin
            errors++;
            $display("FAIL single_area: hits=%0d x=%0d..%0d y=%0d..%0d mask=%h idx=%0d, required 32 4..11 8..11 01 0",
                     st_hits, st_minx, st_maxx, st_miny, st_maxy, st_last_mask, st_last_idx);
        end
    endtask

    task automatic test_overlap();
        hide_all();
        ox[2] = 32'd12; oy[2] = 32'd6;
        ox[4] = 32'd12; oy[4] = 32'd6;
        scan_frame("overlap");
        checks++;
        if (st_hits != 32 || st_minx != 12 || st_maxx != 19 || st_miny != 6 || st_maxy != 9 ||
            st_last_mask !== 8'h14 || st_last_idx !== 3'd2) begin
            errors++;
            $display("FAIL overlap_area: hits=%0d x=%0d..%0d y=%0d..%0d mask=%h idx=%0d, required 32 12..19 6..9 14 2",
                     st_hits, st_minx, st_maxx, st_miny, st_maxy, st_last_mask, st_last_idx);
        end
    endtask

    task automatic test_hide_clip();
        hide_all();
        ox[1] = 32'hFFFF_FFFF; oy[1] = 32'd0;
        ox[5] = 32'd0;         oy[5] = 32'h8000_0000;
        scan_frame("hidden");
        checks++;
        if (st_hits != 0) begin
            errors++;
            $display("FAIL hidden_hits: %0d hit pixels, required 0", st_hits);
        end
        hide_all();
        ox[1] = 32'd28; oy[1] = 32'd0;
        ox[3] = 32'd0;  oy[3] = 32'd22;
        scan_frame("clip");
        checks++;
        if (st_hits != 32 || st_b1_left != 0 || st_b3_top != 0) begin
            errors++;
            $display("FAIL clip_area: hits=%0d obj2_left=%0d obj4_top=%0d, required 32 0 0", st_hits, st_b1_left, st_b3_top);
        end
    endtask

    task automatic test_snapshot();
        bit ok, changed;
        int nc, left, right, exp_left, exp_right;
        hide_all();
        ox[0] = 32'd4; oy[0] = 32'd8;
        left = 0; right = 0; changed = 1'b0;
`ifdef SCREEN_SNAPSHOT_EN
        exp_left = 32; exp_right = 0;
`else
        exp_left = 16; exp_right = 16;
`endif
        goto_frame_start("snapshot", ok);
        if (!ok) return;
        for (int n = 0; n < HT * VT; n++) begin
            if (n > 0) begin
                wait_tick(ok, nc);
                if (!ok) begin
                    checks++; errors++;
                    $display("FAIL snapshot tick_timeout: no pixel_tick after pixel %0d", n);
                    return;
                end
            end
            if (hit_mask[0] === 1'b1 && pix_x >= 10'd4 && pix_x <= 10'd11) left++;
            if (hit_mask[0] === 1'b1 && pix_x >= 10'd20 && pix_x <= 10'd27) right++;
            if (!changed && pix_y === 10'd10) begin
                ox[0] = 32'd20;
                changed = 1'b1;
            end
        end
        checks++;
        if (left != exp_left || right != exp_right) begin
            errors++;
            $display("FAIL snapshot_midframe: hits at x=4 %0d, at x=20 %0d, required %0d and %0d", left, right, exp_left, exp_right);
        end
        scan_frame("snapshot_next");
        checks++;
        if (st_hits != 32 || st_minx != 20 || st_maxx != 27) begin
            errors++;
            $display("FAIL snapshot_next_area: hits=%0d x=%0d..%0d, required 32 20..27", st_hits, st_minx, st_maxx);
        end
    endtask

    task automatic test_sync();
        hide_all();
        scan_frame("sync");
        checks++;
        if (st_hs != (HSE - HSS) * VT || st_vs != (VSE - VSS) * HT ||
            st_se != (VT - VA) * HT || st_av != HA * VA) begin
            errors++;
            $display("FAIL sync_counts: hsync_low=%0d vsync_low=%0d blank=%0d active=%0d, required 120 80 240 768",
                     st_hs, st_vs, st_se, st_av);
        end
    endtask

    initial begin
        reset = 1'b1;
        hide_all();
        test_reset("reset_initial");
        test_single();
        test_overlap();
        test_hide_clip();
        test_snapshot();
        test_sync();
        repeat (333) @(negedge clock);
        test_reset("reset_midframe");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
